// File: rtl/audio_input_capture_pkg.sv
// audio_input_capture_pkg: shared sample type, capture FSM states and magnitude helper.
package sftb_audio_pkg;
   localparam int SAMPLE_W = 32;
   typedef logic [SAMPLE_W-1:0] sample_t;
   typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} cap_state_t;
   // Unsigned magnitude; the most negative value maps onto itself as an unsigned number.
   function automatic sample_t mag(input sample_t s);
      return s[SAMPLE_W-1] ? sample_t'(-s) : s;
   endfunction
endpackage

// File: rtl/audio_input_capture_if.sv
// audio_input_capture_if: sample input and valid/ready drain port of the capture block.
interface audio_input_capture_if;
   import sftb_audio_pkg::*;
   sample_t x;
   logic    x_valid;
   sample_t d_data;
   logic    d_valid;
   logic    d_ready;
   modport master (output x, x_valid, d_ready, input d_data, d_valid);
   modport slave (input x, x_valid, d_ready, output d_data, d_valid);
endinterface

// File: rtl/audio_input_capture_fifo.sv
// audio_input_capture_fifo: synchronous FIFO with a registered show-ahead head.
module audio_capture_fifo
   import sftb_audio_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic          c,
   input  logic          r_n,
   input  logic          push,
   input  logic          pop,
   input  sample_t       din,
   output sample_t       head,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);
   sample_t       mem [DEPTH];
   logic [AW-1:0] wptr, rptr, rptr_nx;
   logic [LW-1:0] level_nx;
   logic          push_ok, pop_ok;
   sample_t       head_nx;
   assign full  = level == LW'(DEPTH);
   assign empty = level == '0;
   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      rptr_nx  = pop_ok ? rptr + 1'b1 : rptr;
      level_nx = level + LW'(push_ok) - LW'(pop_ok);
      // The incoming sample becomes the head directly when it lands in the slot being exposed.
      head_nx  = (level_nx == '0) ? head : (push_ok && wptr == rptr_nx) ? din : mem[rptr_nx];
   end
   always_ff @(posedge c) if (push_ok) mem[wptr] <= din;
   always_ff @(posedge c or negedge r_n) begin
      if (!r_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         head  <= '0;
      end else begin
         wptr  <= push_ok ? wptr + 1'b1 : wptr;
         rptr  <= rptr_nx;
         level <= level_nx;
         head  <= head_nx;
      end
   end
endmodule

// File: rtl/audio_input_capture.sv
// audio_input_capture: start/stop/limit framed sample capture into a FIFO drained over valid/ready.
// Optional AUDIO_CAPTURE_PEAK_EN adds a peak-magnitude output.
module audio_input_capture
   import sftb_audio_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 32,
   parameter int LIMIT = 0
) (
   input  logic                     c,
   input  logic                     r_n,
   input  logic                     start,
   input  logic                     stop,
   audio_input_capture_if.slave     bus,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic [CNT_W-1:0]         count,
   output logic [$clog2(DEPTH):0]   level
`ifdef AUDIO_CAPTURE_PEAK_EN
   ,
   output sample_t                  peak
`endif
);
   cap_state_t state, state_nx;
   logic       full, empty, lim_hit, take, push, pop, begin_cap;
   audio_capture_fifo #(.DEPTH(DEPTH)) u_fifo (
      .c     (c),
      .r_n   (r_n),
      .push  (push),
      .pop   (pop),
      .din   (bus.x),
      .head  (bus.d_data),
      .full  (full),
      .empty (empty),
      .level (level)
   );
   assign bus.d_valid = !empty;
   assign busy        = state != IDLE;
   assign done        = state == FLUSH && empty;
   always_comb begin
      lim_hit   = (LIMIT != 0) && (count >= CNT_W'(LIMIT));
      begin_cap = state == IDLE && start;
      // Once the limit is reached further samples are neither taken nor counted as drops.
      take      = state == CAPTURE && bus.x_valid && !lim_hit;
      push      = take && !full;
      pop       = bus.d_valid && bus.d_ready;
      state_nx  = begin_cap ? CAPTURE :
                  (state == CAPTURE && (stop || lim_hit)) ? FLUSH :
                  (state == FLUSH && empty) ? IDLE : state;
   end
   always_ff @(posedge c or negedge r_n) begin
      if (!r_n) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge c or negedge r_n) begin
      if (!r_n) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (begin_cap) begin
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push && count != '1) count <= count + CNT_W'(1);
         if (take && full) overflow <= 1'b1;
      end
   end
`ifdef AUDIO_CAPTURE_PEAK_EN
   always_ff @(posedge c or negedge r_n) begin
      if (!r_n) peak <= '0;
      else if (begin_cap) peak <= '0;
      else if (push && mag(bus.x) > peak) peak <= mag(bus.x);
   end
`endif
endmodule

// File: tb/tb_audio_input_capture.sv
// tb_audio_input_capture: two capture instances (unlimited and LIMIT=4) checked against a queue model.
module tb_audio_input_capture;
   localparam int DEPTH = 16;
   localparam int LIM [2] = '{0, 4};
   logic c = 1'b0, r_n = 1'b0, st = 1'b0, sp = 1'b0, xv = 1'b0, dr = 1'b0;
   logic [31:0] x = '0;
   logic        busy_o [2], done_o [2], ovf_o [2];
   logic [31:0] cnt_o [2], pk_o [2], dd [2];
   logic [4:0]  lvl_o [2];
   logic        dv [2];
   int          n_chk = 0, n_fail = 0;
   int          m_mode [2], m_level [2];
   longint      m_cnt [2];
   logic        m_ovf [2];
   logic [31:0] m_pk [2];
   logic [31:0] sb0 [$], sb1 [$];
   always #5 c = ~c;
   audio_input_capture_if b0 ();
   audio_input_capture_if b1 ();
   assign b0.x = x;
   assign b0.x_valid = xv;
   assign b0.d_ready = dr;
   assign b1.x = x;
   assign b1.x_valid = xv;
   assign b1.d_ready = dr;
   assign dd[0] = b0.d_data;
   assign dv[0] = b0.d_valid;
   assign dd[1] = b1.d_data;
   assign dv[1] = b1.d_valid;
`ifndef AUDIO_CAPTURE_PEAK_EN
   assign pk_o[0] = '0;
   assign pk_o[1] = '0;
`endif
   audio_input_capture #(.DEPTH(DEPTH), .CNT_W(32), .LIMIT(LIM[0])) u0 (
      .c(c), .r_n(r_n), .start(st), .stop(sp), .bus(b0), .busy(busy_o[0]), .done(done_o[0]),
      .overflow(ovf_o[0]), .count(cnt_o[0]), .level(lvl_o[0])
`ifdef AUDIO_CAPTURE_PEAK_EN
      , .peak(pk_o[0])
`endif
   );
   audio_input_capture #(.DEPTH(DEPTH), .CNT_W(32), .LIMIT(LIM[1])) u1 (
      .c(c), .r_n(r_n), .start(st), .stop(sp), .bus(b1), .busy(busy_o[1]), .done(done_o[1]),
      .overflow(ovf_o[1]), .count(cnt_o[1]), .level(lvl_o[1])
`ifdef AUDIO_CAPTURE_PEAK_EN
      , .peak(pk_o[1])
`endif
   );
   task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, k, a, e);
      end
   endtask
   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0;
         m_level[k] = 0;
         m_cnt[k] = 0;
         m_ovf[k] = 1'b0;
         m_pk[k] = '0;
      end
      sb0.delete();
      sb1.delete();
   endtask
   // Mode 0 idle, 1 capturing, 2 flushing; the model keeps only an occupancy and a sample queue.
   task automatic model_step(input int k, input bit s0, input bit s1, input bit v, input logic [31:0] xx, input bit r);
      bit pop = m_level[k] > 0 && r;
      bit push = 1'b0;
      bit lim = LIM[k] != 0 && m_cnt[k] >= LIM[k];
      logic [32:0] a = xx[31] ? 33'h1_0000_0000 - {1'b0, xx} : {1'b0, xx};
      if (m_mode[k] == 0 && s0) begin
         m_mode[k] = 1;
         m_cnt[k] = 0;
         m_ovf[k] = 1'b0;
         m_pk[k] = '0;
      end else if (m_mode[k] == 1) begin
         if (v && !lim) begin
            if (m_level[k] < DEPTH) push = 1'b1;
            else m_ovf[k] = 1'b1;
         end
         if (push) begin
            if (m_cnt[k] < 64'hFFFF_FFFF) m_cnt[k]++;
            if (a[31:0] > m_pk[k]) m_pk[k] = a[31:0];
            if (k == 0) sb0.push_back(xx);
            else sb1.push_back(xx);
         end
         if (s1 || lim) m_mode[k] = 2;
      end else if (m_mode[k] == 2 && m_level[k] == 0) m_mode[k] = 0;
      m_level[k] = m_level[k] + int'(push) - int'(pop);
   endtask
   task automatic step(input bit s0, input bit s1, input bit v, input logic [31:0] xx, input bit r);
      for (int k = 0; k < 2; k++) begin
         chk("level", k, 32'(lvl_o[k]), 32'(m_level[k]));
         chk("busy", k, 32'(busy_o[k]), 32'(m_mode[k] != 0));
         chk("done", k, 32'(done_o[k]), 32'(m_mode[k] == 2 && m_level[k] == 0));
         chk("overflow", k, 32'(ovf_o[k]), 32'(m_ovf[k]));
         chk("count", k, cnt_o[k], m_cnt[k][31:0]);
         chk("d_valid", k, 32'(dv[k]), 32'(m_level[k] > 0));
`ifdef AUDIO_CAPTURE_PEAK_EN
         chk("peak", k, pk_o[k], m_pk[k]);
`endif
      end
      st = s0;
      sp = s1;
      xv = v;
      x = xx;
      dr = r;
      for (int k = 0; k < 2; k++) model_step(k, s0, s1, v, xx, r);
      @(posedge c);
      #1;
   endtask
   always @(negedge c) begin
      if (r_n) begin
         for (int k = 0; k < 2; k++) begin
            if (dv[k] && dr) begin
               if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL drain[%0d]: got %h with no sample expected", k, dd[k]);
               end else chk("d_data", k, dd[k], k == 0 ? sb0.pop_front() : sb1.pop_front());
            end
         end
      end
   end
   initial begin
      model_reset();
      repeat (2) @(posedge c);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_d_data", k, dd[k], 32'h0);
         chk("rst_d_valid", k, 32'(dv[k]), 32'h0);
         chk("rst_busy", k, 32'(busy_o[k]), 32'h0);
         chk("rst_count", k, cnt_o[k], 32'h0);
      end
      r_n = 1'b1;
      // basic framed capture
      step(1, 0, 0, 0, 1);
      for (int i = 1; i <= 5; i++) step(0, 0, 1, 32'(i), 1);
      step(0, 1, 0, 0, 1);
      repeat (8) step(0, 0, 0, 0, 1);
      // fill past full with the consumer stalled, then push+pop on a full FIFO
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 1, $urandom, 0);
      chk("full_level", 0, 32'(lvl_o[0]), 32'd16);
      chk("full_ovf", 0, 32'(ovf_o[0]), 32'd1);
      chk("limit_count", 1, cnt_o[1], 32'd4);
      step(0, 0, 1, $urandom, 1);
      chk("pushpop_level", 0, 32'(lvl_o[0]), 32'd15);
      step(0, 1, 0, 0, 1);
      repeat (20) step(0, 0, 0, 0, 1);
      // start and stop together while idle
      step(1, 1, 0, 0, 1);
      chk("start_stop_busy", 0, 32'(busy_o[0]), 32'd1);
      step(0, 1, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0, 1);
      // asynchronous reset mid-capture
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 1, $urandom, 0);
      chk("pre_rst_level", 0, 32'(lvl_o[0]), 32'd7);
      st = 0;
      sp = 0;
      xv = 0;
      r_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("arst_d_valid", k, 32'(dv[k]), 32'h0);
         chk("arst_level", k, 32'(lvl_o[k]), 32'h0);
         chk("arst_busy", k, 32'(busy_o[k]), 32'h0);
      end
      model_reset();
      @(posedge c);
      #1;
      r_n = 1'b1;
      step(1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 1, $urandom, 1);
      step(0, 1, 0, 0, 1);
      repeat (5) step(0, 0, 0, 0, 1);
      // peak magnitude including the most negative sample
      step(1, 0, 0, 0, 1);
      step(0, 0, 1, 32'h0000_0010, 1);
      step(0, 0, 1, 32'hFFFF_FF00, 1);
      step(0, 0, 1, 32'h8000_0000, 1);
      step(0, 1, 0, 0, 1);
`ifdef AUDIO_CAPTURE_PEAK_EN
      chk("peak_min", 0, pk_o[0], 32'h8000_0000);
`endif
      repeat (5) step(0, 0, 0, 0, 1);
      // randomized traffic
      repeat (600) step($urandom % 20 == 0, $urandom % 25 == 0, $urandom % 4 != 0, $urandom, $urandom % 3 != 0);
      step(0, 1, 0, 0, 1);
      repeat (40) step(0, 0, 0, 0, 1);
      chk("sb_empty", 0, 32'(sb0.size()), 32'h0);
      chk("sb_empty", 1, 32'(sb1.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
